// File: rtl/collatz_pkg.sv
// collatz_pkg: shared widths and enums for the Collatz engine
package collatz_pkg;
   localparam int VW = 32;
   localparam int SW = 16;
   typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;
   typedef enum logic [1:0] {ERR_NONE, ERR_ZERO, ERR_OVF, ERR_TIMEOUT} err_t;
endpackage

// File: rtl/collatz_step.sv
// collatz_step: one combinational Collatz map application
// Ports: i_val value in; o_next mapped value; o_ovf odd step exceeds 32 bits
module collatz_step
   import collatz_pkg::*;
(
   input  logic [VW-1:0] i_val,
   output logic [VW-1:0] o_next,
   output logic          o_ovf
);
   logic [VW+1:0] w_odd;
   // 3n+1 at 34 bits so the carry into bits 33:32 is visible
   assign w_odd  = {2'b00, i_val} + {1'b0, i_val, 1'b0} + {{(VW+1){1'b0}}, 1'b1};
   assign o_ovf  = i_val[0] & (|w_odd[VW+1:VW]);
   assign o_next = i_val[0] ? w_odd[VW-1:0] : {1'b0, i_val[VW-1:1]};
endmodule

// File: rtl/collatz_engine.sv
// collatz_engine: iterates the Collatz map from n to 1 with go/done handshake
// Ports: clk, reset_n (async low); go/n start; dout iterate; done/err/err_code
//        completion status; busy while running; steps count; peak max iterate
module collatz_engine
   import collatz_pkg::*;
#(
   parameter logic [SW-1:0] MAX_STEPS = 16'd1000
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          go,
   input  logic [VW-1:0] n,
   output logic [VW-1:0] dout,
   output logic          done,
   output logic          err,
   output logic [1:0]    err_code,
   output logic          busy,
   output logic [SW-1:0] steps,
   output logic [VW-1:0] peak
);
   state_t        r_state;
   err_t          r_err;
   logic [VW-1:0] r_dout;
   logic [VW-1:0] r_peak;
   logic [SW-1:0] r_steps;
   logic [VW-1:0] w_next;
   logic          w_ovf;

   collatz_step u_step (
      .i_val (r_dout),
      .o_next(w_next),
      .o_ovf (w_ovf)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_err   <= ERR_NONE;
         r_dout  <= '0;
         r_peak  <= '0;
         r_steps <= '0;
      end else if (go) begin
         r_state <= RUN;
         r_err   <= ERR_NONE;
         r_dout  <= n;
         r_peak  <= n;
         r_steps <= '0;
      end else if (r_state == RUN) begin
         if (r_dout == {{(VW-1){1'b0}}, 1'b1}) begin
            r_state <= DONE;
         end else if (r_dout == '0) begin
            r_state <= ERR;
            r_err   <= ERR_ZERO;
         end else if (r_steps == MAX_STEPS) begin
            r_state <= ERR;
            r_err   <= ERR_TIMEOUT;
         end else if (w_ovf) begin
            // dout keeps the value whose successor does not fit
            r_state <= ERR;
            r_err   <= ERR_OVF;
         end else begin
            r_dout  <= w_next;
            r_steps <= r_steps + 1'b1;
            r_peak  <= (w_next > r_peak) ? w_next : r_peak;
         end
      end
   end

   assign dout     = r_dout;
   assign peak     = r_peak;
   assign steps    = r_steps;
   assign err_code = r_err;
   assign done     = (r_state == DONE);
   assign err      = (r_state == ERR);
   assign busy     = (r_state == RUN);
endmodule

// File: tb/tb_collatz_engine.sv
// tb_collatz_engine: scoreboard bench for collatz_engine against an arithmetic model
module tb_collatz_engine;
   typedef struct {
      bit          sel;
      bit          dn;
      logic [1:0]  code;
      logic [15:0] st;
      logic [31:0] pk;
      logic [31:0] dv;
   } exp_t;

   logic        clk, reset_n, go_a, go_b;
   logic [31:0] n;
   logic [31:0] a_dout, b_dout, a_peak, b_peak;
   logic [15:0] a_steps, b_steps;
   logic [1:0]  a_code, b_code;
   logic        a_done, a_err, a_busy, b_done, b_err, b_busy;
   exp_t        q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   bit          pa = 0, pb = 0;

   collatz_engine #(.MAX_STEPS(16'd1000)) dut_a (
      .clk(clk), .reset_n(reset_n), .go(go_a), .n(n), .dout(a_dout), .done(a_done),
      .err(a_err), .err_code(a_code), .busy(a_busy), .steps(a_steps), .peak(a_peak)
   );
   collatz_engine #(.MAX_STEPS(16'd10)) dut_b (
      .clk(clk), .reset_n(reset_n), .go(go_b), .n(n), .dout(b_dout), .done(b_done),
      .err(b_err), .err_code(b_code), .busy(b_busy), .steps(b_steps), .peak(b_peak)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Collatz rules applied directly with wide integer arithmetic
   function automatic exp_t model(input bit s, input logic [31:0] n0, input int maxs);
      exp_t e;
      longint v = longint'(n0);
      longint pk = v;
      int st = 0;
      logic [1:0] c = 0;
      bit dn = 0;
      while (1) begin
         if (v == 1) begin dn = 1; break; end
         if (v == 0) begin c = 1; break; end
         if (st == maxs) begin c = 3; break; end
         if (v % 2 == 1 && 3 * v + 1 >= 64'd4294967296) begin c = 2; break; end
         v = (v % 2 == 1) ? 3 * v + 1 : v / 2;
         st++;
         if (v > pk) pk = v;
      end
      e.sel = s; e.dn = dn; e.code = c; e.st = 16'(st); e.pk = 32'(pk); e.dv = 32'(v);
      return e;
   endfunction

   task automatic check(input bit s, input bit dn, input bit er, input bit bz,
                        input logic [1:0] c, input logic [15:0] st,
                        input logic [31:0] pk, input logic [31:0] dv);
      exp_t e;
      if (q.size() == 0) begin
         n_cmp++; n_bad++;
         $display("FAIL unexpected_completion dut=%0d got done=%0d err=%0d expected none", s, dn, er);
      end else begin
         e = q.pop_front();
         chk("sel", 64'(s), 64'(e.sel));
         chk("done", 64'(dn), 64'(e.dn));
         chk("err", 64'(er), 64'(!e.dn));
         chk("busy", 64'(bz), 64'(0));
         chk("err_code", 64'(c), 64'(e.code));
         chk("steps", 64'(st), 64'(e.st));
         chk("peak", 64'(pk), 64'(e.pk));
         chk("dout", 64'(dv), 64'(e.dv));
      end
   endtask

   // Monitor: compare on each new completion of either engine
   always @(negedge clk) begin
      if ((a_done | a_err) && !pa) check(0, a_done, a_err, a_busy, a_code, a_steps, a_peak, a_dout);
      if ((b_done | b_err) && !pb) check(1, b_done, b_err, b_busy, b_code, b_steps, b_peak, b_dout);
      pa = a_done | a_err;
      pb = b_done | b_err;
   end

   task automatic start(input bit s, input logic [31:0] v);
      @(negedge clk);
      n = v;
      if (s) go_b = 1; else go_a = 1;
      @(negedge clk);
      go_a = 0;
      go_b = 0;
   endtask

   task automatic wait_fin(input bit s);
      int k = 0;
      while (!(s ? (b_done | b_err) : (a_done | a_err)) && k < 1200) begin
         @(negedge clk);
         k++;
      end
      if (k == 1200) begin
         n_cmp++; n_bad++;
         $display("FAIL wait_timeout dut=%0d got no completion expected completion", s);
      end
   endtask

   task automatic run(input bit s, input logic [31:0] v);
      q.push_back(model(s, v, s ? 10 : 1000));
      start(s, v);
      wait_fin(s);
   endtask

   initial begin
      int cnt, k;
      logic [31:0] v;
      reset_n = 0; go_a = 0; go_b = 0; n = 0;
      repeat (3) @(negedge clk);
      chk("rst_dout", 64'(a_dout), 0);
      chk("rst_flags", 64'({a_done, a_err, a_busy, a_code}), 0);
      chk("rst_steps_peak", 64'({a_steps, a_peak}), 0);
      reset_n = 1;

      // async reset mid-run
      start(0, 27);
      repeat (20) @(negedge clk);
      #2 reset_n = 0;
      #1;
      chk("midrst_dout", 64'(a_dout), 0);
      chk("midrst_flags", 64'({a_done, a_err, a_busy, a_code}), 0);
      chk("midrst_steps_peak", 64'({a_steps, a_peak}), 0);
      @(negedge clk);
      reset_n = 1;
      run(0, 6);

      // n=1 timing
      q.push_back(model(0, 1, 1000));
      start(0, 1);
      chk("n1_dout_e1", 64'(a_dout), 1);
      chk("n1_busy_e1", 64'({a_busy, a_done}), 64'(2'b10));
      @(negedge clk);
      chk("n1_done_e2", 64'(a_done), 1);

      // n=27 with busy length
      q.push_back(model(0, 27, 1000));
      start(0, 27);
      cnt = 0; k = 0;
      while (!a_done && k < 300) begin
         if (a_busy) cnt++;
         @(negedge clk);
         k++;
      end
      chk("n27_busy_cycles", 64'(cnt), 112);
      chk("n27_peak", 64'(a_peak), 9232);

      run(0, 0);
      run(0, 32'hFFFFFFFF);
      chk("ovf_dout_hold", 64'(a_dout), 64'(32'hFFFFFFFF));

      // timeout on the short-limit engine, then full run of 7
      run(1, 27);
      chk("timeout_steps", 64'(b_steps), 10);
      run(1, 7);
      run(0, 7);
      chk("n7_steps", 64'(a_steps), 16);
      chk("n7_peak", 64'(a_peak), 52);

      // restart mid-run
      start(0, 27);
      k = 0;
      while (a_steps != 5 && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("restart_at_step5", 64'(a_steps), 5);
      q.push_back(model(0, 3, 1000));
      start(0, 3);
      chk("no_stale_done", 64'({a_done, a_err}), 0);
      wait_fin(0);

      // go held high keeps resampling
      @(negedge clk);
      go_a = 1;
      for (int i = 0; i < 4; i++) begin
         v = $urandom_range(2, 1000);
         n = v;
         if (i == 3) q.push_back(model(0, v, 1000));
         @(negedge clk);
         chk("held_go_dout", 64'(a_dout), 64'(v));
         chk("held_go_steps", 64'({a_busy, a_steps}), 64'({1'b1, 16'd0}));
      end
      go_a = 0;
      wait_fin(0);

      // randomized runs
      for (int i = 0; i < 14; i++) begin
         v = (i % 4 == 3) ? $urandom() : 32'($urandom_range(1, 5000));
         run(i % 3 == 0, v);
      end

      repeat (2) @(negedge clk);
      chk("queue_empty", 64'(q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
